regfile: RTL and testbench

- General-purpose register file of the MIPS pipeline; 32 x 32-bit.
- Responder to the decode stage's two register read requests: enable, address, data.
- Accepts the write-back port from the WB stage.
- Provides combinational reads, a synchronous write, write-through bypass, hard-wired zero in `$0`, and optional EX/MEM forwarding at the read ports.

---
 rtl/regfile.sv | 51 +++++
 tb/tb_regfile.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32x32 MIPS register file, sync write, write-through bypass, $0 hard-wired; REGFILE_FWD_EN adds EX/MEM forwarding.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_FWD_EN
    ,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata
`endif
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_wb1, w_wb2, w_src1, w_src2;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (we && waddr != '0) begin
            r_regs[waddr] <= wdata;
        end
    end
    assign w_wb1 = (we && waddr == raddr1) ? wdata : r_regs[raddr1];
    assign w_wb2 = (we && waddr == raddr2) ? wdata : r_regs[raddr2];
`ifdef REGFILE_FWD_EN
    // Youngest producer wins: EX ahead of MEM ahead of WB.
    assign w_src1 = (ex_wreg && ex_wd == raddr1)   ? ex_wdata  :
                    (mem_wreg && mem_wd == raddr1) ? mem_wdata : w_wb1;
    assign w_src2 = (ex_wreg && ex_wd == raddr2)   ? ex_wdata  :
                    (mem_wreg && mem_wd == raddr2) ? mem_wdata : w_wb2;
`else
    assign w_src1 = w_wb1;
    assign w_src2 = w_wb2;
`endif
    assign rdata1 = (rst || !re1 || raddr1 == '0) ? '0 : w_src1;
    assign rdata2 = (rst || !re2 || raddr2 == '0) ? '0 : w_src2;
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed checks of reset, write/read, $0, bypass, port independence and optional forwarding.
module tb_regfile;
    logic        clk, rst, we, re1, re2;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, rdata1, rdata2;
    int n_pass = 0, n_chk = 0;
`ifdef REGFILE_FWD_EN
    logic        ex_wreg, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
`endif

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
`ifdef REGFILE_FWD_EN
        , .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1; waddr = a; wdata = d;
        tick();
        we = 0; wdata = '0;
    endtask

    initial begin
        logic [31:0] pat;
        rst = 1; we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
`ifdef REGFILE_FWD_EN
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
`endif
        tick();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 9;
        #1 chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);
        rst = 0;
        wr(5, 32'hDEADBEEF);
        #1 chk("pre_rst_r5", rdata1, 32'hDEADBEEF);
        rst = 1; we = 1; waddr = 6; wdata = 32'h1234;
        #1 chk("rst_comb_zero", rdata1, 32'h0);
        tick();
        rst = 0; we = 0; wdata = 0;
        re2 = 1; raddr2 = 6;
        #1 chk("rst_clear_r5", rdata1, 32'h0);
        chk("rst_wins_r6", rdata2, 32'h0);

        wr(3, 32'h0000ABCD);
        re1 = 1; raddr1 = 3;
        #1 chk("wr_rd_r3", rdata1, 32'h0000ABCD);
        re1 = 0;
        #1 chk("re1_off", rdata1, 32'h0);
        re1 = 1;

        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; re2 = 1; raddr2 = 0;
        #1 chk("r0_same_cycle", rdata2, 32'h0);
        tick();
        we = 0;
        #1 chk("r0_after", rdata2, 32'h0);
        tick();
        chk("r0_later", rdata2, 32'h0);

        we = 1; waddr = 7; wdata = 32'h11112222; raddr1 = 7; raddr2 = 7;
        #1 chk("byp_rd1", rdata1, 32'h11112222);
        chk("byp_rd2", rdata2, 32'h11112222);
        tick();
        we = 1; waddr = 8; wdata = 32'h55555555;
        #1 chk("byp_other_addr", rdata1, 32'h11112222);
        tick();
        we = 0;

        wr(1, 32'hA);
        wr(2, 32'hB);
        raddr1 = 2; raddr2 = 1; re1 = 1; re2 = 1;
        #1 chk("ind_rd1", rdata1, 32'hB);
        chk("ind_rd2", rdata2, 32'hA);
        re2 = 0;
        #1 chk("ind_re2_off", rdata2, 32'h0);
        chk("ind_rd1_hold", rdata1, 32'hB);
        re2 = 1;

        for (int i = 1; i < 32; i++) wr(i[4:0], 32'h01010101 * i ^ 32'hC0DE0000);
        for (int i = 0; i < 32; i++) begin
            raddr1 = i[4:0]; raddr2 = 5'(31 - i);
            pat = (i == 0) ? 32'h0 : (32'h01010101 * i ^ 32'hC0DE0000);
            #1 chk("sweep_rd1", rdata1, pat);
            pat = (i == 31) ? 32'h0 : (32'h01010101 * (31 - i) ^ 32'hC0DE0000);
            chk("sweep_rd2", rdata2, pat);
        end

`ifdef REGFILE_FWD_EN
        wr(9, 32'h1);
        raddr1 = 9; re1 = 1;
        we = 1; waddr = 9; wdata = 32'h2;
        mem_wreg = 1; mem_wd = 9; mem_wdata = 32'h3;
        ex_wreg = 1; ex_wd = 9; ex_wdata = 32'h4;
        #1 chk("fwd_ex", rdata1, 32'h4);
        ex_wreg = 0;
        #1 chk("fwd_mem", rdata1, 32'h3);
        mem_wreg = 0;
        #1 chk("fwd_wb", rdata1, 32'h2);
        we = 0;
        #1 chk("fwd_reg", rdata1, 32'h1);
        raddr1 = 0; ex_wreg = 1; ex_wd = 0; ex_wdata = 32'h77;
        #1 chk("fwd_r0_ignored", rdata1, 32'h0);
        ex_wreg = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
